// File: rtl/a5_pkg.sv
// Shared definitions for the A5/1 keystream controller: FSM state encoding,
// Wishbone register offsets, LFSR geometry and default session lengths.
package a5_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_KEY   = 3'd1,
    ST_LOAD_FRAME = 3'd2,
    ST_MIX        = 3'd3,
    ST_RUN        = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

  // Register offsets (address bits [7:0])
  localparam logic [7:0] ADR_KEY_LO = 8'h00;
  localparam logic [7:0] ADR_KEY_HI = 8'h04;
  localparam logic [7:0] ADR_FRAME  = 8'h08;
  localparam logic [7:0] ADR_CTRL   = 8'h0C;
  localparam logic [7:0] ADR_STATUS = 8'h10;
  localparam logic [7:0] ADR_DATA   = 8'h14;

  // LFSR geometry: lengths, feedback tap masks, clocking-bit positions
  localparam int unsigned R1_LEN = 19;
  localparam int unsigned R2_LEN = 22;
  localparam int unsigned R3_LEN = 23;

  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h7_2000;   // 13,16,17,18
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h30_0000;  // 20,21
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h70_0080;  // 7,20,21,22

  localparam int unsigned R1_CLK = 8;
  localparam int unsigned R2_CLK = 10;
  localparam int unsigned R3_CLK = 10;

  localparam int unsigned DEF_MIX_CYCLES = 100;
  localparam int unsigned DEF_KS_BITS    = 228;

  localparam int unsigned KEY_BITS   = 64;
  localparam int unsigned FRAME_BITS = 22;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned CNT_W      = 16;

  // Majority of three bits
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/a5_maj_lfsr.sv
// One A5/1 shift register. Shifts left on step; new bit 0 is the XOR of the
// tapped bits and load_bit. clear zeroes the register (session start).
// Ports: clk, reset_n, clear, step, load_bit in; q (register), clk_bit out.
module a5_maj_lfsr #(
  parameter int unsigned     LEN     = 19,
  parameter logic [LEN-1:0]  TAPS    = '0,
  parameter int unsigned     CLK_BIT = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear,
  input  logic           step,
  input  logic           load_bit,
  output logic [LEN-1:0] q,
  output logic           clk_bit
);

  logic feedback;

  assign feedback = (^(q & TAPS)) ^ load_bit;
  assign clk_bit  = q[CLK_BIT];

  // Shift register state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (step) begin
      q <= {q[LEN-2:0], feedback};
    end
  end

endmodule

// File: rtl/a5_keystream_ctrl.sv
// A5/1 keystream generator behind a Wishbone slave. Software loads key and
// frame, writes START, and pops 32-bit keystream words from DATA. A full word
// that cannot be handed over (previous word unread) stalls generation.
// Ports: clk, reset_n; Wishbone slave wbs_stb_i/cyc_i/we_i/sel_i/adr_i/dat_i
// in, registered wbs_ack_o/wbs_dat_o out.
module a5_keystream_ctrl
  import a5_pkg::*;
#(
  parameter int unsigned MIX_CYCLES = DEF_MIX_CYCLES,
  parameter int unsigned KS_BITS    = DEF_KS_BITS
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  state_t state, state_nxt;

  logic [KEY_BITS-1:0]   key_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt, bit_inc;
  logic [WORD_W-1:0]     word_sr, word_sr_nxt, out_word, out_word_nxt, sr_shift;
  logic                  word_valid, word_valid_nxt, done, done_nxt;

  logic [R1_LEN-1:0] r1_q;
  logic [R2_LEN-1:0] r2_q;
  logic [R3_LEN-1:0] r3_q;
  logic c1, c2, c3, maj, ks_bit;
  logic lfsr_clear, load_bit, step1, step2, step3;
  logic last, word_full, stall;

  logic        access, wr_acc, rd_acc, start_req, abort_req, pop, busy;
  logic [7:0]  adr8;
  logic [31:0] rdata;
  logic        unused_sink;

  // Bus decode: a request is taken only while ack is low
  assign adr8      = wbs_adr_i[7:0];
  assign access    = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr_acc    = access & wbs_we_i;
  assign rd_acc    = access & ~wbs_we_i;
  assign abort_req = wr_acc & (adr8 == ADR_CTRL) & wbs_dat_i[1];
  assign start_req = wr_acc & (adr8 == ADR_CTRL) & wbs_dat_i[0] & ~wbs_dat_i[1];
  assign pop       = rd_acc & (adr8 == ADR_DATA) & word_valid;
  assign busy      = (state == ST_LOAD_KEY) | (state == ST_LOAD_FRAME) |
                     (state == ST_MIX) | (state == ST_RUN);

  assign unused_sink = ^{wbs_sel_i, wbs_adr_i[31:8], r1_q[R1_LEN-2:0],
                         r2_q[R2_LEN-2:0], r3_q[R3_LEN-2:0]};

  assign maj    = maj3(c1, c2, c3);
  assign ks_bit = r1_q[R1_LEN-1] ^ r2_q[R2_LEN-1] ^ r3_q[R3_LEN-1];

  a5_maj_lfsr #(.LEN(R1_LEN), .TAPS(R1_TAPS), .CLK_BIT(R1_CLK)) u_r1 (
    .clk(clk), .reset_n(reset_n), .clear(lfsr_clear), .step(step1),
    .load_bit(load_bit), .q(r1_q), .clk_bit(c1));

  a5_maj_lfsr #(.LEN(R2_LEN), .TAPS(R2_TAPS), .CLK_BIT(R2_CLK)) u_r2 (
    .clk(clk), .reset_n(reset_n), .clear(lfsr_clear), .step(step2),
    .load_bit(load_bit), .q(r2_q), .clk_bit(c2));

  a5_maj_lfsr #(.LEN(R3_LEN), .TAPS(R3_TAPS), .CLK_BIT(R3_CLK)) u_r3 (
    .clk(clk), .reset_n(reset_n), .clear(lfsr_clear), .step(step3),
    .load_bit(load_bit), .q(r3_q), .clk_bit(c3));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state, LFSR control and keystream datapath next values
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bit_cnt_nxt    = bit_cnt;
    word_sr_nxt    = word_sr;
    out_word_nxt   = out_word;
    word_valid_nxt = word_valid & ~pop;
    done_nxt       = done;
    lfsr_clear     = 1'b0;
    load_bit       = 1'b0;
    step1          = 1'b0;
    step2          = 1'b0;
    step3          = 1'b0;
    bit_inc        = bit_cnt + CNT_W'(1);
    sr_shift       = {word_sr[WORD_W-2:0], ks_bit};
    last           = (bit_inc == CNT_W'(KS_BITS));
    word_full      = (bit_inc[4:0] == 5'd0) | last;
    // A completed word needs out_word free, or freed by a pop this cycle
    stall          = word_full & word_valid & ~pop;

    if (abort_req) begin
      state_nxt      = ST_IDLE;
      cnt_nxt        = '0;
      bit_cnt_nxt    = '0;
      word_sr_nxt    = '0;
      word_valid_nxt = 1'b0;
      done_nxt       = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_req) begin
            state_nxt   = ST_LOAD_KEY;
            lfsr_clear  = 1'b1;
            cnt_nxt     = '0;
            bit_cnt_nxt = '0;
            word_sr_nxt = '0;
            done_nxt    = 1'b0;
          end
        end
        ST_LOAD_KEY: begin
          load_bit = key_q[cnt[5:0]];
          step1 = 1'b1;
          step2 = 1'b1;
          step3 = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(KEY_BITS - 1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_LOAD_FRAME;
          end
        end
        ST_LOAD_FRAME: begin
          load_bit = frame_q[cnt[4:0]];
          step1 = 1'b1;
          step2 = 1'b1;
          step3 = 1'b1;
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(FRAME_BITS - 1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_MIX;
          end
        end
        ST_MIX: begin
          step1 = (c1 == maj);
          step2 = (c2 == maj);
          step3 = (c3 == maj);
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(MIX_CYCLES - 1)) begin
            cnt_nxt   = '0;
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            step1 = (c1 == maj);
            step2 = (c2 == maj);
            step3 = (c3 == maj);
            bit_cnt_nxt = bit_inc;
            if (word_full) begin
              out_word_nxt   = sr_shift;
              word_valid_nxt = 1'b1;
              word_sr_nxt    = '0;
            end else begin
              word_sr_nxt = sr_shift;
            end
            if (last) begin
              state_nxt = ST_DONE;
              done_nxt  = 1'b1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Keystream datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      word_sr    <= '0;
      out_word   <= '0;
      word_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      word_sr    <= word_sr_nxt;
      out_word   <= out_word_nxt;
      word_valid <= word_valid_nxt;
      done       <= done_nxt;
    end
  end

  // Key and frame registers, writable only when no session is in progress
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q   <= '0;
      frame_q <= '0;
    end else if (wr_acc && !busy) begin
      if (adr8 == ADR_KEY_LO) key_q[31:0]  <= wbs_dat_i;
      if (adr8 == ADR_KEY_HI) key_q[63:32] <= wbs_dat_i;
      if (adr8 == ADR_FRAME)  frame_q      <= wbs_dat_i[FRAME_BITS-1:0];
    end
  end

  // Read mux
  always_comb begin
    rdata = '0;
    case (adr8)
      ADR_STATUS: rdata = {29'd0, word_valid, done, busy};
      ADR_DATA:   rdata = word_valid ? out_word : 32'd0;
      default:    rdata = '0;
    endcase
  end

  // Registered single-cycle acknowledge; data is zero whenever ack is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= access;
      wbs_dat_o <= rd_acc ? rdata : 32'd0;
    end
  end

endmodule

// File: tb/tb_a5_keystream_ctrl.sv
// Directed bench for a5_keystream_ctrl: register access, zero-key stall
// behaviour, keystream words against a bit-level A5/1 reference, abort,
// ignored writes while busy, exact done timing and mid-session reset.
module tb_a5_keystream_ctrl;
  import a5_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_stb, wb_cyc, wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat;
  logic        wb_ack;
  logic [31:0] wb_dat_o;

  int unsigned edge_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_w [8];

  a5_keystream_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .wbs_stb_i(wb_stb), .wbs_cyc_i(wb_cyc), .wbs_we_i(wb_we),
    .wbs_sel_i(wb_sel), .wbs_adr_i(wb_adr), .wbs_dat_i(wb_dat),
    .wbs_ack_o(wb_ack), .wbs_dat_o(wb_dat_o));

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One Wishbone access; e is the rising edge at which the request is taken
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] r, output int unsigned e);
    @(negedge clk);
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = w; wb_adr = a; wb_dat = d;
    e = edge_cnt + 1;
    @(negedge clk);
    chk($sformatf("ack@%02h", a[7:0]), {31'd0, wb_ack}, 32'd1);
    r = wb_dat_o;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
  endtask

  // Access taken exactly at rising edge tgt
  task automatic acc_at(input int unsigned tgt, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] r);
    int unsigned e;
    while (edge_cnt + 2 < tgt) @(negedge clk);
    wb(w, a, d, r, e);
  endtask

  task automatic maj_step(inout logic [18:0] a, inout logic [21:0] b, inout logic [22:0] c);
    int  votes;
    logic m;
    votes = a[8] + b[10] + c[10];
    m = (votes >= 2);
    if (a[8] == m)  a = {a[17:0], a[13] ^ a[16] ^ a[17] ^ a[18]};
    if (b[10] == m) b = {b[20:0], b[20] ^ b[21]};
    if (c[10] == m) c = {c[21:0], c[7] ^ c[20] ^ c[21] ^ c[22]};
  endtask

  // Reference A5/1 keystream packed into the eight expected words
  task automatic gen_words(input logic [63:0] k, input logic [21:0] f);
    logic [18:0] a;
    logic [21:0] b;
    logic [22:0] c;
    logic        bi, o;
    logic [31:0] w;
    int          n, wi;
    a = '0; b = '0; c = '0;
    for (int i = 0; i < 86; i++) begin
      bi = (i < 64) ? k[i] : f[i-64];
      a = {a[17:0], a[13] ^ a[16] ^ a[17] ^ a[18] ^ bi};
      b = {b[20:0], b[20] ^ b[21] ^ bi};
      c = {c[21:0], c[7] ^ c[20] ^ c[21] ^ c[22] ^ bi};
    end
    for (int i = 0; i < 100; i++) maj_step(a, b, c);
    w = '0; n = 0; wi = 0;
    for (int i = 0; i < 228; i++) begin
      o = a[18] ^ b[21] ^ c[22];
      maj_step(a, b, c);
      w = {w[30:0], o};
      n++;
      if (n == 32) begin
        exp_w[wi] = w;
        wi++;
        w = '0;
        n = 0;
      end
    end
    exp_w[7] = w;
  endtask

  // Scheduled reads: word 1 popped on the edge word 2 completes, later words
  // shortly after each completion, STATUS probed at st_edge
  task automatic run_timed(input int unsigned t, input int unsigned st_edge,
                           input logic [31:0] st_exp, input string tag);
    logic [31:0] r;
    acc_at(t + 250, 1'b0, {24'd0, ADR_DATA}, 32'd0, r);
    chk({tag, "_w0"}, r, exp_w[0]);
    acc_at(t + 252, 1'b0, {24'd0, ADR_DATA}, 32'd0, r);
    chk({tag, "_w1"}, r, exp_w[1]);
    for (int k = 3; k <= 7; k++) begin
      acc_at(t + 186 + 32 * k + 2, 1'b0, {24'd0, ADR_DATA}, 32'd0, r);
      chk($sformatf("%s_w%0d", tag, k - 1), r, exp_w[k-1]);
    end
    acc_at(st_edge, 1'b0, {24'd0, ADR_STATUS}, 32'd0, r);
    chk({tag, "_status_probe"}, r, st_exp);
    acc_at(t + 418, 1'b0, {24'd0, ADR_DATA}, 32'd0, r);
    chk({tag, "_w7"}, r, exp_w[7]);
    acc_at(t + 420, 1'b0, {24'd0, ADR_STATUS}, 32'd0, r);
    chk({tag, "_status_end"}, r, 32'h2);
  endtask

  initial begin
    logic [31:0] r;
    int unsigned e, t;
    int          n, guard;
    logic        disturbed;

    reset_n = 1'b0;
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    wb_sel = 4'hF; wb_adr = '0; wb_dat = '0;
    #12;
    chk("rst_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle register reads and unmapped addresses
    wb(1'b0, {24'd0, ADR_STATUS}, 32'd0, r, e);
    chk("idle_status", r, 32'h0);
    wb(1'b0, {24'd0, ADR_DATA}, 32'd0, r, e);
    chk("idle_data", r, 32'h0);
    wb(1'b0, 32'h0000_0018, 32'd0, r, e);
    chk("rd_18", r, 32'h0);
    wb(1'b0, 32'h0000_00FC, 32'd0, r, e);
    chk("rd_fc", r, 32'h0);

    // Strobe held high: acks alternate, data zero while ack low
    @(negedge clk);
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = {24'd0, ADR_STATUS};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b2b_ack%0d", i), {31'd0, wb_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 1) chk($sformatf("b2b_dat%0d", i), wb_dat_o, 32'd0);
    end
    wb_stb = 1'b0; wb_cyc = 1'b0;

    // Zero key and frame: all-zero keystream, stall after the first word
    wb(1'b1, {24'd0, ADR_KEY_LO}, 32'd0, r, e);
    wb(1'b1, {24'd0, ADR_KEY_HI}, 32'd0, r, e);
    wb(1'b1, {24'd0, ADR_FRAME}, 32'd0, r, e);
    wb(1'b1, {24'd0, ADR_CTRL}, 32'd1, r, t);
    acc_at(t + 300, 1'b0, {24'd0, ADR_STATUS}, 32'd0, r);
    chk("zero_stall_status", r, 32'h5);
    wb(1'b0, 32'hABCD_0010, 32'd0, r, e);
    chk("zero_alias_status", r, 32'h5);
    for (int k = 0; k < 8; k++) begin
      guard = 0;
      r = '0;
      while (!r[2] && guard < 200) begin
        wb(1'b0, {24'd0, ADR_STATUS}, 32'd0, r, e);
        guard++;
      end
      chk($sformatf("zero_valid%0d", k), {31'd0, r[2]}, 32'd1);
      wb(1'b0, {24'd0, ADR_DATA}, 32'd0, r, e);
      chk($sformatf("zero_w%0d", k), r, 32'h0);
    end
    wb(1'b0, {24'd0, ADR_STATUS}, 32'd0, r, e);
    chk("zero_done_status", r, 32'h2);

    // Reference key and frame, read scheduled onto a word-completion edge
    gen_words(64'h0123_4567_89AB_CDEF, 22'h134);
    wb(1'b1, {24'd0, ADR_KEY_LO}, 32'h89AB_CDEF, r, e);
    wb(1'b1, {24'd0, ADR_KEY_HI}, 32'h0123_4567, r, e);
    wb(1'b1, {24'd0, ADR_FRAME}, 32'h0000_0134, r, e);
    wb(1'b1, {24'd0, ADR_CTRL}, 32'd1, r, t);
    run_timed(t, t + 414, 32'h1, "runA");

    // Restart from DONE with continuous polling; START and KEY_LO mid-run
    wb(1'b1, {24'd0, ADR_CTRL}, 32'd1, r, t);
    n = 0; guard = 0; disturbed = 1'b0;
    while (n < 8 && guard < 400) begin
      guard++;
      wb(1'b0, {24'd0, ADR_STATUS}, 32'd0, r, e);
      if (r[2]) begin
        wb(1'b0, {24'd0, ADR_DATA}, 32'd0, r, e);
        chk($sformatf("poll_w%0d", n), r, exp_w[n]);
        n++;
      end
      if (!disturbed && n == 2) begin
        wb(1'b1, {24'd0, ADR_CTRL}, 32'd1, r, e);
        wb(1'b1, {24'd0, ADR_KEY_LO}, 32'hFFFF_FFFF, r, e);
        disturbed = 1'b1;
      end
    end
    chk("poll_count", n, 32'd8);
    wb(1'b0, {24'd0, ADR_STATUS}, 32'd0, r, e);
    chk("poll_status_end", r, 32'h2);

    // ABORT during MIX, then a fresh session with the unchanged key
    wb(1'b1, {24'd0, ADR_CTRL}, 32'd1, r, t);
    acc_at(t + 120, 1'b1, {24'd0, ADR_CTRL}, 32'd3, r);
    acc_at(t + 122, 1'b0, {24'd0, ADR_STATUS}, 32'd0, r);
    chk("abort_status", r, 32'h0);
    wb(1'b0, {24'd0, ADR_DATA}, 32'd0, r, e);
    chk("abort_data", r, 32'h0);
    wb(1'b1, {24'd0, ADR_CTRL}, 32'd1, r, t);
    run_timed(t, t + 415, 32'h6, "runB");

    // Reset pulse mid-RUN while an ack is on the bus
    wb(1'b1, {24'd0, ADR_CTRL}, 32'd1, r, t);
    while (edge_cnt < t + 300) @(negedge clk);
    wb_stb = 1'b1; wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = {24'd0, ADR_STATUS};
    @(negedge clk);
    chk("pre_rst_ack", {31'd0, wb_ack}, 32'd1);
    chk("pre_rst_dat", wb_dat_o, 32'h5);
    reset_n = 1'b0;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    #1;
    chk("mid_rst_ack", {31'd0, wb_ack}, 32'd0);
    chk("mid_rst_dat", wb_dat_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wb(1'b0, {24'd0, ADR_STATUS}, 32'd0, r, e);
    chk("post_rst_status", r, 32'h0);
    wb(1'b0, {24'd0, ADR_DATA}, 32'd0, r, e);
    chk("post_rst_data", r, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
